// File: rtl/rab_arbiter_if.sv
// Request/response signals between the two RAB masters, the arbiter and the register file.
// slave: the arbiter's view; master: the requesters plus register file driving the arbiter.
interface rab_arbiter_if #(
  parameter int unsigned RAB_ADDR_WIDTH = 9
);
  logic                      mcu_rab_write;
  logic                      mcu_rab_read;
  logic [RAB_ADDR_WIDTH-1:0] mcu_i2c_addr;
  logic [7:0]                mcu_rab_wdata;
  logic                      mcu_rab_ack;
  logic [7:0]                mcu_rab_rdata;

  logic                      i2c_rab_write;
  logic                      i2c_rab_read;
  logic [RAB_ADDR_WIDTH-1:0] i2c_rab_addr;
  logic [7:0]                i2c_rab_wdata;
  logic                      i2c_rab_ack;
  logic [7:0]                i2c_rab_rdata;

  logic [RAB_ADDR_WIDTH-1:0] rab_addr;
  logic [7:0]                rab_wdata;
  logic                      rab_write;
  logic                      rab_read;
  logic [7:0]                rab_rdata;
  logic                      rab_ready;
  logic                      rab_err;

  modport slave (
    input  mcu_rab_write, mcu_rab_read, mcu_i2c_addr, mcu_rab_wdata,
    output mcu_rab_ack, mcu_rab_rdata,
    input  i2c_rab_write, i2c_rab_read, i2c_rab_addr, i2c_rab_wdata,
    output i2c_rab_ack, i2c_rab_rdata,
    output rab_addr, rab_wdata, rab_write, rab_read, rab_err,
    input  rab_rdata, rab_ready
  );

  modport master (
    output mcu_rab_write, mcu_rab_read, mcu_i2c_addr, mcu_rab_wdata,
    input  mcu_rab_ack, mcu_rab_rdata,
    output i2c_rab_write, i2c_rab_read, i2c_rab_addr, i2c_rab_wdata,
    input  i2c_rab_ack, i2c_rab_rdata,
    input  rab_addr, rab_wdata, rab_write, rab_read, rab_err,
    output rab_rdata, rab_ready
  );
endinterface

// File: rtl/rab_arbiter.sv
// Round-robin arbiter between MCU and I2C masters onto the shared register access bus,
// with registered strobes, one-cycle ack and a BUSY timeout that returns 8'hFF plus rab_err.
module rab_arbiter #(
  parameter int unsigned RAB_ADDR_WIDTH = 9,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic         clk,
  input  logic         rst,
  rab_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                    state;
  logic                      last_i2c;
  logic [7:0]                cnt;
  logic [RAB_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                wdata_q;
  logic                      write_q;
  logic                      read_q;
  logic                      mcu_ack_q;
  logic                      i2c_ack_q;
  logic [7:0]                mcu_rdata_q;
  logic [7:0]                i2c_rdata_q;
  logic                      err_q;

  logic                      mcu_req;
  logic                      i2c_req;
  logic                      grant_i2c;
  logic                      sel_write;
  logic                      timed_out;
  logic [7:0]                resp_data;

  always_comb begin
    mcu_req   = bus.mcu_rab_write | bus.mcu_rab_read;
    i2c_req   = bus.i2c_rab_write | bus.i2c_rab_read;
    grant_i2c = i2c_req & (~mcu_req | ~last_i2c);
    // Read and write together is treated as a write.
    sel_write = grant_i2c ? bus.i2c_rab_write : bus.mcu_rab_write;
    timed_out = (cnt == 8'(TIMEOUT));
    resp_data = 8'hFF;
    if (bus.rab_ready) resp_data = write_q ? 8'h00 : bus.rab_rdata;
  end

  // last_i2c is updated on every grant, so during BUSY/RESP it also names the current owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_i2c    <= 1'b1;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      mcu_ack_q   <= 1'b0;
      i2c_ack_q   <= 1'b0;
      mcu_rdata_q <= '0;
      i2c_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mcu_req | i2c_req) begin
            state    <= BUSY;
            last_i2c <= grant_i2c;
            addr_q   <= grant_i2c ? bus.i2c_rab_addr  : bus.mcu_i2c_addr;
            wdata_q  <= grant_i2c ? bus.i2c_rab_wdata : bus.mcu_rab_wdata;
            write_q  <= sel_write;
            read_q   <= ~sel_write;
            cnt      <= '0;
          end
        end
        BUSY: begin
          if (bus.rab_ready | timed_out) begin
            state   <= RESP;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            err_q   <= ~bus.rab_ready;
            if (last_i2c) begin
              i2c_ack_q   <= 1'b1;
              i2c_rdata_q <= resp_data;
            end else begin
              mcu_ack_q   <= 1'b1;
              mcu_rdata_q <= resp_data;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          mcu_ack_q <= 1'b0;
          i2c_ack_q <= 1'b0;
          err_q     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mcu_rab_ack   = mcu_ack_q;
  assign bus.mcu_rab_rdata = mcu_rdata_q;
  assign bus.i2c_rab_ack   = i2c_ack_q;
  assign bus.i2c_rab_rdata = i2c_rdata_q;
  assign bus.rab_addr      = addr_q;
  assign bus.rab_wdata     = wdata_q;
  assign bus.rab_write     = write_q;
  assign bus.rab_read      = read_q;
  assign bus.rab_err       = err_q;

endmodule
